jpeg_stream_feeder: RTL and testbench

Byte-stream source for the JPEG decoder's 32-bit word input port. It accepts a JPEG file as a byte stream from an upstream loader (SD/UART/DMA), packs the bytes big-endian into 32-bit words and buffers them in a show-ahead FIFO. Words are presented on the decoder's `DataIn` / `DataInEnable` / `DataInRead` interface. It is the transmitting end of the protocol the decoder receives, and replaces the memory-backed word feeder used in simulation.

---
 rtl/jpeg_feed_pkg.sv | 54 +++++
 rtl/jpeg_stream_feeder_if.sv | 36 +++
 rtl/jpeg_feed_fifo.sv | 66 ++++++
 rtl/jpeg_stream_feeder.sv | 113 +++++++++++
 tb/tb_jpeg_stream_feeder.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/jpeg_feed_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : jpeg_feed_pkg                                                  |
// | Purpose : Shared types and constants for the JPEG byte-stream feeder:    |
// |           FSM state encoding, byte-lane bit positions inside a word,     |
// |           default pad byte and the word-assembly helper.                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package jpeg_feed_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    DRAIN = 2'd2
  } feed_state_e;

  // Big-endian lane placement: lane 0 is the first byte of the word.
  localparam int LANE0_MSB = 31;
  localparam int LANE1_MSB = 23;
  localparam int LANE2_MSB = 15;
  localparam int LANE3_MSB = 7;

  localparam logic [1:0] LAST_LANE        = 2'd3;
  localparam logic [7:0] DEFAULT_PAD_BYTE = 8'h00;

  // Build the word being pushed when the byte for 'lane' arrives.
  // 'sh' holds the earlier bytes of this word right-justified (newest in
  // [7:0]); lanes after 'lane' take the pad value.
  function automatic logic [31:0] pack_word(input logic [23:0] sh,
                                            input logic [7:0]  b,
                                            input logic [1:0]  lane,
                                            input logic [7:0]  pad);
    logic [31:0] word;
    word = {4{pad}};
    unique case (lane)
      2'd0: word[LANE0_MSB -: 8] = b;
      2'd1: begin
        word[LANE0_MSB -: 8] = sh[7:0];
        word[LANE1_MSB -: 8] = b;
      end
      2'd2: begin
        word[LANE0_MSB -: 16] = sh[15:0];
        word[LANE2_MSB -: 8]  = b;
      end
      default: begin
        word[LANE0_MSB -: 24] = sh;
        word[LANE3_MSB -: 8]  = b;
      end
    endcase
    return word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jpeg_stream_feeder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : jpeg_stream_feeder_if                                        |
// | Purpose   : Bundles the upstream byte handshake and the decoder-side     |
// |             word handshake plus status of the JPEG stream feeder.        |
// | Ports     : ByteIn/ByteInValid/ByteInLast/ByteInReady  byte side        |
// |             DataOut/DataOutEnable/DataOutRead           word side        |
// |             Done/Underrun/WordCount                     status           |
// |             slave  = feeder view, master = loader/decoder view           |
// | Rev       : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface jpeg_stream_feeder_if #(
  parameter int CNT_W = 20
);
  logic [7:0]       ByteIn;
  logic             ByteInValid;
  logic             ByteInLast;
  logic             ByteInReady;
  logic [31:0]      DataOut;
  logic             DataOutEnable;
  logic             DataOutRead;
  logic             Done;
  logic             Underrun;
  logic [CNT_W-1:0] WordCount;

  modport slave (
    input  ByteIn, ByteInValid, ByteInLast, DataOutRead,
    output ByteInReady, DataOut, DataOutEnable, Done, Underrun, WordCount
  );

  modport master (
    output ByteIn, ByteInValid, ByteInLast, DataOutRead,
    input  ByteInReady, DataOut, DataOutEnable, Done, Underrun, WordCount
  );
endinterface
`default_nettype wire

// File: rtl/jpeg_feed_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : jpeg_feed_fifo                                                 |
// | Purpose : Synchronous show-ahead FIFO; rdata is the head word whenever   |
// |           the FIFO is non-empty, zero otherwise.                         |
// | Ports   : clk, rst (sync, active high)                                   |
// |           push/wdata  write request (ignored when full)                  |
// |           pop/rdata   consume head (ignored when empty)                  |
// |           full, empty, count  occupancy status                           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module jpeg_feed_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 32
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  push,
  input  wire logic [WIDTH-1:0]      wdata,
  input  wire logic                  pop,
  output logic      [WIDTH-1:0]      rdata,
  output logic                       full,
  output logic                       empty,
  output logic      [DEPTH_LOG2:0]   count
);
  localparam int                  DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Occupancy can reach DEPTH exactly, so the MSB alone flags full.
  assign full    = count[DEPTH_LOG2];
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Data array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/jpeg_stream_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : jpeg_stream_feeder                                             |
// | Purpose : Packs a JPEG byte stream big-endian into 32-bit words, buffers |
// |           them in a show-ahead FIFO and presents them to the decoder's   |
// |           DataIn/DataInEnable/DataInRead port.                           |
// | Ports   : clk, rst (sync, active high)                                   |
// |           bus (jpeg_stream_feeder_if.slave): byte input handshake, word  |
// |           output handshake, Done pulse, sticky Underrun, WordCount       |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module jpeg_stream_feeder
  import jpeg_feed_pkg::*;
#(
  parameter int         DEPTH_LOG2 = 4,
  parameter logic [7:0] PAD_BYTE   = DEFAULT_PAD_BYTE,
  parameter int         CNT_W      = 20
) (
  input  wire logic           clk,
  input  wire logic           rst,
  jpeg_stream_feeder_if.slave bus
);
  localparam logic [DEPTH_LOG2:0] OCC_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  feed_state_e           state;
  feed_state_e           state_nxt;
  logic [1:0]            lane;
  logic [23:0]           shift;
  logic                  ready;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  last_pop;
  logic [31:0]           push_word;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DEPTH_LOG2:0]   fifo_count;
  logic                  done_q;
  logic                  underrun_q;
  logic [CNT_W-1:0]      word_count;

  // rst gates ready combinationally so the loader never sees a stale
  // handshake while the block is being cleared.
  assign ready     = ((state == IDLE) || (state == PACK)) && !fifo_full && !rst;
  assign accept    = bus.ByteInValid && ready;
  // A word closes on lane 3 or on the final byte (remaining lanes padded).
  assign push      = accept && ((lane == LAST_LANE) || bus.ByteInLast);
  assign pop       = bus.DataOutRead && !fifo_empty;
  assign last_pop  = pop && (fifo_count == OCC_ONE);
  assign push_word = pack_word(shift, bus.ByteIn, lane, PAD_BYTE);

  jpeg_feed_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_word),
    .pop   (pop),
    .rdata (bus.DataOut),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = bus.ByteInLast ? DRAIN : PACK;
      PACK:  if (accept && bus.ByteInLast) state_nxt = DRAIN;
      // The empty term is only a safety exit; DRAIN is always entered with
      // the final word just pushed.
      DRAIN: if (last_pop || fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lane       <= 2'd0;
      shift      <= '0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      word_count <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == DRAIN) && last_pop;
      if (bus.DataOutRead && fifo_empty) underrun_q <= 1'b1;

      if (accept) begin
        shift <= {shift[15:0], bus.ByteIn};
        lane  <= push ? 2'd0 : lane + 2'd1;
      end

      // First byte of a stream restarts the count (it may already be a push).
      if (accept && (state == IDLE)) begin
        word_count <= push ? CNT_ONE : '0;
      end else if (push && (word_count != '1)) begin
        word_count <= word_count + CNT_ONE;
      end
    end
  end

  assign bus.ByteInReady   = ready;
  assign bus.DataOutEnable = !fifo_empty;
  assign bus.Done          = done_q;
  assign bus.Underrun      = underrun_q;
  assign bus.WordCount     = word_count;
endmodule
`default_nettype wire

// File: tb/tb_jpeg_stream_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_jpeg_stream_feeder                                          |
// | Purpose : Self-checking bench for jpeg_stream_feeder. Expected words are |
// |           computed from the accepted byte list (groups of four, big-     |
// |           endian, pad-filled tail) and compared with words observed on  |
// |           the read side.                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_jpeg_stream_feeder;
  localparam int         CNT_W      = 20;
  localparam int         DEPTH_LOG2 = 4;
  localparam logic [7:0] PAD        = 8'h00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jpeg_stream_feeder_if #(.CNT_W(CNT_W)) bus();

  jpeg_stream_feeder #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .PAD_BYTE   (PAD),
    .CNT_W      (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  logic [7:0]  stim_q[$];
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  // Reference: every 4 bytes form a word, first byte most significant;
  // a short tail is filled with the pad byte.
  task automatic build_expected(input int nbytes);
    logic [31:0] w;
    exp_q.delete();
    for (int i = 0; i < nbytes; i += 4) begin
      w = '0;
      for (int j = 0; j < 4; j++)
        w = (w << 8) | ((i + j < nbytes) ? {24'h0, stim_q[i+j]} : {24'h0, PAD});
      exp_q.push_back(w);
    end
  endtask

  // One clock: drive, sample handshakes at the falling edge, observe
  // registered outputs just after the rising edge.
  task automatic step(input logic v, input logic l, input logic [7:0] b,
                      input logic r, output bit acc);
    bus.ByteInValid = v;
    bus.ByteInLast  = l;
    bus.ByteIn      = b;
    bus.DataOutRead = r;
    @(negedge clk);
    acc = v && bus.ByteInReady;
    if (r && bus.DataOutEnable) got_q.push_back(bus.DataOut);
    @(posedge clk);
    #1;
    if (bus.Done) done_cnt++;
  endtask

  task automatic do_reset();
    bus.ByteInValid = 0; bus.ByteInLast = 0; bus.ByteIn = 0; bus.DataOutRead = 0;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    got_q.delete();
    done_cnt = 0;
  endtask

  // rd_mode: 0 never read, 1 always read, 2 random read
  task automatic send_stream(input int rd_mode, input bit gaps, input bit with_last);
    bit acc; int tries; logic v, r;
    for (int i = 0; i < stim_q.size(); i++) begin
      acc = 0; tries = 0;
      while (!acc && tries < 200) begin
        v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        r = (rd_mode == 1) ? 1'b1 : (rd_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        step(v, with_last && (i == stim_q.size() - 1), stim_q[i], r, acc);
        tries++;
      end
      if (!acc) begin
        n_checks++; n_fail++;
        $display("FAIL byte_accept_timeout: byte %0d not accepted after %0d cycles", i, tries);
        return;
      end
    end
  endtask

  task automatic wait_done(input int rd_mode);
    bit acc; int t; logic r;
    t = 0;
    while (done_cnt == 0 && t < 200) begin
      r = (rd_mode == 1) ? 1'b1 : (rd_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      step(0, 0, 8'h00, r, acc);
      t++;
    end
    n_checks++;
    if (done_cnt == 0) begin
      n_fail++;
      $display("FAIL done_timeout: no Done after %0d cycles, required a pulse", t);
    end
    step(0, 0, 8'h00, 0, acc);  // a stretched pulse would count twice
  endtask

  task automatic test_reset();
    bus.ByteInValid = 1; bus.ByteInLast = 0; bus.ByteIn = 8'h5A; bus.DataOutRead = 1;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks++; if (bus.ByteInReady !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b need 0", bus.ByteInReady); end
    n_checks++; if (bus.DataOut !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h need 0", bus.DataOut); end
    n_checks++; if (bus.DataOutEnable !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b need 0", bus.DataOutEnable); end
    n_checks++; if (bus.Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b need 0", bus.Done); end
    n_checks++; if (bus.Underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b need 0", bus.Underrun); end
    n_checks++; if (bus.WordCount !== '0) begin n_fail++; $display("FAIL reset_count: got %0d need 0", bus.WordCount); end
    bus.ByteInValid = 0; bus.DataOutRead = 0;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.ByteInReady !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b need 1", bus.ByteInReady); end
    got_q.delete(); done_cnt = 0;
  endtask

  task automatic test_full_words();
    do_reset();
    stim_q = '{8'hFF, 8'hD8, 8'hFF, 8'hE0, 8'h00, 8'h10, 8'h4A, 8'h46};
    send_stream(1, 0, 1);
    wait_done(1);
    n_checks++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL full_words_count: got %0d words need 2", got_q.size()); end
    n_checks++; if (got_q.size() < 1 || got_q[0] !== 32'hFFD8FFE0) begin n_fail++; $display("FAIL full_words_w0: got %h need ffd8ffe0", (got_q.size() > 0) ? got_q[0] : 32'hx); end
    n_checks++; if (got_q.size() < 2 || got_q[1] !== 32'h00104A46) begin n_fail++; $display("FAIL full_words_w1: got %h need 00104a46", (got_q.size() > 1) ? got_q[1] : 32'hx); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL full_words_done: got %0d pulses need 1", done_cnt); end
    n_checks++; if (bus.WordCount !== 20'd2) begin n_fail++; $display("FAIL full_words_wordcount: got %0d need 2", bus.WordCount); end
    n_checks++; if (bus.ByteInReady !== 1'b1) begin n_fail++; $display("FAIL full_words_idle: ready got %b need 1", bus.ByteInReady); end
  endtask

  task automatic test_partial_word();
    do_reset();
    stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hD9};
    send_stream(0, 0, 1);
    wait_done(1);
    n_checks++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL partial_count: got %0d words need 2", got_q.size()); end
    n_checks++; if (got_q.size() < 1 || got_q[0] !== 32'h11223344) begin n_fail++; $display("FAIL partial_w0: got %h need 11223344", (got_q.size() > 0) ? got_q[0] : 32'hx); end
    n_checks++; if (got_q.size() < 2 || got_q[1] !== 32'hD9000000) begin n_fail++; $display("FAIL partial_w1: got %h need d9000000", (got_q.size() > 1) ? got_q[1] : 32'hx); end
    n_checks++; if (bus.WordCount !== 20'd2) begin n_fail++; $display("FAIL partial_wordcount: got %0d need 2", bus.WordCount); end
  endtask

  task automatic test_back_pressure();
    bit acc; int acc_n; int first_reject;
    do_reset();
    stim_q.delete();
    for (int i = 0; i < 80; i++) stim_q.push_back(8'($urandom));
    acc_n = 0; first_reject = -1;
    for (int i = 0; i < 80; i++) begin
      step(1, 0, stim_q[acc_n], 0, acc);
      if (acc) acc_n++;
      else if (first_reject < 0) first_reject = i;
    end
    n_checks++; if (acc_n !== 64) begin n_fail++; $display("FAIL bp_accepted: got %0d bytes need 64", acc_n); end
    n_checks++; if (first_reject !== 64) begin n_fail++; $display("FAIL bp_first_reject: got cycle %0d need 64", first_reject); end
    n_checks++; if (bus.ByteInReady !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b need 0", bus.ByteInReady); end
    n_checks++; if (bus.WordCount !== 20'd16) begin n_fail++; $display("FAIL bp_wordcount: got %0d need 16", bus.WordCount); end
    step(0, 0, 8'h00, 1, acc);
    n_checks++; if (bus.ByteInReady !== 1'b1) begin n_fail++; $display("FAIL bp_ready_return: got %b need 1", bus.ByteInReady); end
    for (int i = 0; i < 15; i++) step(0, 0, 8'h00, 1, acc);
    n_checks++; if (bus.DataOutEnable !== 1'b0) begin n_fail++; $display("FAIL bp_empty_after_16: enable got %b need 0", bus.DataOutEnable); end
    build_expected(64);
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL bp_words: got %0d need %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_word_%0d: got %h need %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_underrun();
    bit acc;
    do_reset();
    stim_q.delete();
    for (int i = 0; i < 8; i++) stim_q.push_back(8'($urandom));
    send_stream(0, 0, 1);
    wait_done(1);
    n_checks++; if (bus.Underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_clean: got %b need 0", bus.Underrun); end
    step(0, 0, 8'h00, 1, acc);
    n_checks++; if (bus.Underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_set: got %b need 1", bus.Underrun); end
    n_checks++; if (bus.WordCount !== 20'd2) begin n_fail++; $display("FAIL underrun_wordcount: got %0d need 2", bus.WordCount); end
    n_checks++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL underrun_no_pop: got %0d words need 2", got_q.size()); end
    got_q.delete(); done_cnt = 0;
    stim_q.delete();
    for (int i = 0; i < 4; i++) stim_q.push_back(8'($urandom));
    send_stream(0, 0, 1);
    wait_done(1);
    build_expected(4);
    n_checks++; if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL underrun_traffic: got %0d words need 1 of %h", got_q.size(), exp_q[0]); end
    n_checks++; if (bus.Underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky: got %b need 1", bus.Underrun); end
    do_reset();
    n_checks++; if (bus.Underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_cleared: got %b need 0", bus.Underrun); end
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    stim_q.delete();
    for (int i = 0; i < 6; i++) stim_q.push_back(8'($urandom));
    send_stream(0, 0, 0);
    n_checks++; if (bus.DataOutEnable !== 1'b1) begin n_fail++; $display("FAIL mid_pre_enable: got %b need 1", bus.DataOutEnable); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.ByteInReady !== 1'b0 || bus.Done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready_done: got %b/%b need 0/0", bus.ByteInReady, bus.Done); end
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (bus.DataOutEnable !== 1'b0 || bus.DataOut !== 32'h0) begin n_fail++; $display("FAIL mid_rst_fifo: enable %b data %h need 0/0", bus.DataOutEnable, bus.DataOut); end
    n_checks++; if (bus.WordCount !== '0 || bus.Underrun !== 1'b0 || bus.Done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_status: count %0d underrun %b done %b need 0/0/0", bus.WordCount, bus.Underrun, bus.Done); end
    got_q.delete(); done_cnt = 0;
    stim_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_stream(0, 0, 1);
    wait_done(1);
    n_checks++; if (got_q.size() !== 1 || got_q[0] !== 32'hAABBCCDD) begin n_fail++; $display("FAIL mid_new_stream: got %0d words first %h need aabbccdd", got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'hx); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL mid_new_done: got %0d pulses need 1", done_cnt); end
  endtask

  task automatic test_simultaneous();
    bit acc;
    do_reset();
    stim_q.delete();
    for (int i = 0; i < 8; i++) stim_q.push_back(8'($urandom));
    build_expected(8);
    for (int i = 0; i < 7; i++) step(1, 0, stim_q[i], 0, acc);
    n_checks++; if (bus.DataOutEnable !== 1'b1 || bus.DataOut !== exp_q[0]) begin n_fail++; $display("FAIL simul_occ1: enable %b data %h need 1/%h", bus.DataOutEnable, bus.DataOut, exp_q[0]); end
    step(1, 1, stim_q[7], 1, acc);  // push word 1 and pop word 0 on one edge
    n_checks++; if (!acc) begin n_fail++; $display("FAIL simul_accept: got %b need 1", acc); end
    n_checks++; if (bus.DataOutEnable !== 1'b1 || bus.DataOut !== exp_q[1]) begin n_fail++; $display("FAIL simul_head: enable %b data %h need 1/%h", bus.DataOutEnable, bus.DataOut, exp_q[1]); end
    step(0, 0, 8'h00, 1, acc);
    n_checks++; if (bus.DataOutEnable !== 1'b0) begin n_fail++; $display("FAIL simul_occ_after: enable %b need 0", bus.DataOutEnable); end
    n_checks++; if (got_q.size() !== 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin n_fail++; $display("FAIL simul_order: got %0d words need %h %h", got_q.size(), exp_q[0], exp_q[1]); end
    n_checks++; if (bus.Underrun !== 1'b0) begin n_fail++; $display("FAIL simul_underrun: got %b need 0", bus.Underrun); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL simul_done: got %0d pulses need 1", done_cnt); end
  endtask

  task automatic test_random_streams();
    int n;
    for (int s = 0; s < 6; s++) begin
      got_q.delete(); done_cnt = 0;
      n = $urandom_range(1, 40);
      stim_q.delete();
      for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
      send_stream(2, 1, 1);
      wait_done(2);
      build_expected(n);
      n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand%0d_words: got %0d need %0d (n=%0d)", s, got_q.size(), exp_q.size(), n); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_word_%0d: got %h need %h", s, i, got_q[i], exp_q[i]); end
      end
      n_checks++; if (bus.WordCount !== CNT_W'((n + 3) / 4)) begin n_fail++; $display("FAIL rand%0d_wordcount: got %0d need %0d", s, bus.WordCount, (n + 3) / 4); end
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rand%0d_done: got %0d pulses need 1", s, done_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_partial_word();
    test_back_pressure();
    test_underrun();
    test_reset_mid_stream();
    test_simultaneous();
    test_random_streams();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
